qupls4_return_addr_stack: RTL
=============================

// Module: qupls4_return_addr_stack
// PURPOSE
//  Return-address stack (RAS) for the Qupls4 front end; consumer side of call detection.
//  - Decode flags a call (BSR/JSR/JSRN): the stack pushes the return address.
//  - Decode flags a return (RTS): the stack pops and supplies the predicted target.
//  - Circular buffer; overwrites the oldest entry on overflow.
//  - Pointer checkpoint and restore for branch-miss recovery.
// PARAMETERS
//  DEPTH  16  number of entries; must be a power of 2, >= 2
//  AWID   4   pointer width = $clog2(DEPTH)
//  PCW    32  return-address width in bits
// PORTS
//  clk          in   1         clock; all state updates on the rising edge
//  rst          in   1         synchronous, active-high reset
//  en           in   1         pipeline advance; push/pop ignored when 0
//  push         in   1         call decoded this cycle
//  push_addr    in   PCW       return address (call PC + call length)
//  pop          in   1         return decoded this cycle
//  restore      in   1         load checkpoint (branch miss)
//  restore_ptr  in   AWID      checkpointed ptr
//  restore_cnt  in   AWID+1    checkpointed cnt
//  tos_addr     out  PCW       predicted return target = mem[ptr]
//  tos_valid    out  1         cnt != 0
//  ptr          out  AWID      current top-of-stack index (for checkpointing)
//  cnt          out  AWID+1    valid entries, 0..DEPTH
//  overflow     out  1         1-cycle pulse: push while cnt==DEPTH
//  underflow    out  1         1-cycle pulse: pop while cnt==0
// BEHAVIOUR
//  Reset
//  - ptr=0, cnt=0, all mem entries=0, overflow=0, underflow=0.
//  - Therefore tos_addr=0 and tos_valid=0.
//  Outputs
//  - tos_addr and tos_valid are combinational from registered ptr/cnt/mem.
//  - A pop presented in cycle N uses tos_addr as seen in cycle N.
//  - A push in cycle N is visible on tos_addr in cycle N+1 (latency 1).
//  Priority: rst > restore > (en & push/pop). Cases per edge:
//  - restore: ptr<=restore_ptr, cnt<=restore_cnt; mem not modified; push/pop that cycle dropped; no pulses.
//  - en=0, no restore: all state held; overflow/underflow <=0.
//  - push only:
//    - ptr<=ptr+1 (mod DEPTH), mem[ptr+1]<=push_addr.
//    - cnt<=cnt+1 if cnt<DEPTH, else unchanged with overflow pulse (oldest entry lost).
//  - pop only, cnt>0: ptr<=ptr-1 (mod DEPTH), cnt<=cnt-1; mem unchanged.
//  - pop only, cnt==0: no state change; underflow pulse.
//  - push & pop, cnt>0: mem[ptr]<=push_addr (replace top); ptr and cnt unchanged.
//  - push & pop, cnt==0: behaves as push only; underflow pulse also asserted.
//  Pulses
//  - overflow/underflow are registered; high exactly one cycle after the causing edge.
//  - Cleared on every other cycle.
//  Wrap-around: ptr arithmetic is modulo DEPTH; cnt saturates at DEPTH and floors at 0.
//  Reset mid-operation: all in-flight push/pop/restore that cycle discarded; reset values apply next cycle.
//  restore_cnt > DEPTH: clamp to DEPTH.
// TESTING
//  1) After rst: push 0x1000, then push 0x2000 ->
//     tos_addr=0x2000, cnt=2, ptr=2. Then pop -> tos_addr=0x1000, cnt=1, ptr=1.
//  2) Push 17 addresses 0x100..0x110 (DEPTH=16) ->
//     overflow pulses once on the 17th push; cnt=16, ptr=1, tos_addr=0x110.
//     16 pops return 0x110..0x101; a 17th pop -> underflow, no state change.
//  3) cnt=3, tos=0x300: push 0x400 & pop same cycle ->
//     cnt=3, ptr unchanged, tos_addr=0x400. Same stimulus with cnt=0 -> cnt=1, tos=0x400, underflow=1.
//  4) Record ptr=2/cnt=2; push 0xA, push 0xB; then restore ->
//     ptr=2, cnt=2, tos_addr = original entry 2. A push with restore that cycle is dropped.
//  5) en=0 with push=1, pop=1 for 3 cycles -> ptr/cnt/tos unchanged, no pulses.
//     rst asserted during a push -> next cycle cnt=0, tos_valid=0, tos_addr=0.

Source files
------------

// File: rtl/qupls4_return_addr_stack.sv
`default_nettype none
// ============================================================================
//  Module      : qupls4_return_addr_stack
//  Description : Return-address stack for the Qupls4 front end. A decoded
//                call pushes its return address and a decoded return pops
//                the predicted target. The stack is a circular buffer that
//                overwrites its oldest entry on overflow. The pointer and
//                count can be checkpointed and restored on a branch miss.
//  Revision    : 1.0  initial release
// ============================================================================
module qupls4_return_addr_stack #(
    parameter int DEPTH = 16,
    parameter int AWID  = $clog2(DEPTH),
    parameter int PCW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            push,
    input  logic [PCW-1:0]  push_addr,
    input  logic            pop,
    input  logic            restore,
    input  logic [AWID-1:0] restore_ptr,
    input  logic [AWID:0]   restore_cnt,
    output logic [PCW-1:0]  tos_addr,
    output logic            tos_valid,
    output logic [AWID-1:0] ptr,
    output logic [AWID:0]   cnt,
    output logic            overflow,
    output logic            underflow
);

    localparam logic [AWID:0]   C_FULL    = (AWID+1)'(DEPTH);
    localparam logic [AWID:0]   C_CNT_ONE = (AWID+1)'(1);
    localparam logic [AWID-1:0] C_PTR_ONE = AWID'(1);

    logic [PCW-1:0]  r_mem [DEPTH];
    logic [AWID-1:0] r_ptr;
    logic [AWID:0]   r_cnt;
    logic            r_overflow;
    logic            r_underflow;

    logic            w_empty;
    logic            w_full;
    logic [AWID-1:0] w_ptr_inc;
    logic [AWID-1:0] w_ptr_dec;
    logic [AWID:0]   w_restore_cnt;
    logic            w_we;
    logic [AWID-1:0] w_waddr;

    assign w_empty       = (r_cnt == '0);
    assign w_full        = (r_cnt == C_FULL);
    assign w_ptr_inc     = r_ptr + C_PTR_ONE;
    assign w_ptr_dec     = r_ptr - C_PTR_ONE;
    // A checkpoint can never legitimately exceed the stack size; clamp it.
    assign w_restore_cnt = (restore_cnt > C_FULL) ? C_FULL : restore_cnt;

    // Memory write decode: a push&pop on a non-empty stack replaces the top
    // in place, every other push writes the slot above the current top.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_ptr;
        if (!restore && en && push) begin
            w_we    = 1'b1;
            w_waddr = (pop && !w_empty) ? r_ptr : w_ptr_inc;
        end
    end

    // One register per stack entry, cleared on reset, written by the decode.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_mem[gi] <= '0;
                end else if (w_we && (w_waddr == AWID'(gi))) begin
                    r_mem[gi] <= push_addr;
                end
            end
        end
    endgenerate

    // Pointer, count and the one-cycle overflow/underflow pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            if (restore) begin
                r_ptr <= restore_ptr;
                r_cnt <= w_restore_cnt;
            end else if (en) begin
                if (push && pop && !w_empty) begin
                    // top replaced in place; pointer and count unchanged
                end else if (push) begin
                    r_ptr <= w_ptr_inc;
                    if (w_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                    if (pop) begin
                        r_underflow <= 1'b1;
                    end
                end else if (pop) begin
                    if (w_empty) begin
                        r_underflow <= 1'b1;
                    end else begin
                        r_ptr <= w_ptr_dec;
                        r_cnt <= r_cnt - C_CNT_ONE;
                    end
                end
            end
        end
    end

    assign tos_addr  = r_mem[r_ptr];
    assign tos_valid = !w_empty;
    assign ptr       = r_ptr;
    assign cnt       = r_cnt;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire
